// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready back-pressure, sideband tag and flush.
// Mux level k shifts by 2^k; levels are grouped REG_EVERY per registered stage.
module shifter_pipe #(
    parameter int BITS      = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BITS-1:0]         in_data,
    input  logic [$clog2(BITS)-1:0] in_shamt,
    input  logic [2:0]              in_op,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BITS-1:0]         out_data,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int LVLS = $clog2(BITS);
    localparam int LAT  = (LVLS + REG_EVERY - 1) / REG_EVERY;

    function automatic logic is_pass(input logic [2:0] op);
        return (op == 3'b010) || (op[2:1] == 2'b11);
    endfunction

    // op[0] picks direction, op[2] selects rotate, op 011 fills with the captured MSB
    function automatic logic [BITS-1:0] shift_lvl(input logic [BITS-1:0] x, input int k,
                                                  input logic [2:0] op, input logic msb);
        int              amt;
        logic [BITS-1:0] fill_l;
        logic [BITS-1:0] fill_r;
        amt    = 1 << k;
        fill_l = '0;
        fill_r = '0;
        if (op[2]) begin
            fill_l = x >> (BITS - amt);
            fill_r = x << (BITS - amt);
        end else if (op[1] && msb) begin
            fill_r = ~({BITS{1'b1}} >> amt);
        end
        if (op[0]) return (x >> amt) | fill_r;
        else       return (x << amt) | fill_l;
    endfunction

    logic [LAT-1:0]   v_q, v_d, adv, src_v;
    logic [BITS-1:0]  data_q [LAT];
    logic [BITS-1:0]  data_d [LAT];
    logic [LVLS-1:0]  shamt_q [LAT];
    logic [LVLS-1:0]  shamt_d [LAT];
    logic [2:0]       op_q [LAT];
    logic [2:0]       op_d [LAT];
    logic             msb_q [LAT];
    logic             msb_d [LAT];
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];

    logic [BITS-1:0]  src_data [LAT];
    logic [LVLS-1:0]  src_shamt [LAT];
    logic [2:0]       src_op [LAT];
    logic             src_msb [LAT];
    logic [TAG_W-1:0] src_tag [LAT];
    logic             adv_acc;
    logic [BITS-1:0]  x;

    // Ready chain runs combinationally from the output back to the input.
    always_comb begin
        adv_acc      = !v_q[LAT-1] || out_ready;
        adv[LAT-1]   = adv_acc;
        for (int s = LAT - 2; s >= 0; s--) begin
            adv_acc = !v_q[s] || adv_acc;
            adv[s]  = adv_acc;
        end
    end

    assign in_ready = adv[0] && !flush;

    always_comb begin
        src_v        = '0;
        src_v[0]     = in_valid && in_ready;
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt;
        src_op[0]    = in_op;
        src_msb[0]   = in_data[BITS-1];
        src_tag[0]   = in_tag;
        for (int s = 1; s < LAT; s++) begin
            src_v[s]     = v_q[s-1];
            src_data[s]  = data_q[s-1];
            src_shamt[s] = shamt_q[s-1];
            src_op[s]    = op_q[s-1];
            src_msb[s]   = msb_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end
    end

    always_comb begin
        v_d     = v_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        msb_d   = msb_q;
        tag_d   = tag_q;
        x       = '0;
        for (int s = 0; s < LAT; s++) begin
            x = src_data[s];
            if (!is_pass(src_op[s])) begin
                for (int k = 0; k < LVLS; k++) begin
                    if ((k / REG_EVERY) == s && src_shamt[s][k])
                        x = shift_lvl(x, k, src_op[s], src_msb[s]);
                end
            end
            if (adv[s] && !flush) begin
                v_d[s] = src_v[s];
                if (src_v[s]) begin
                    data_d[s]  = x;
                    shamt_d[s] = src_shamt[s];
                    op_d[s]    = src_op[s];
                    msb_d[s]   = src_msb[s];
                    tag_d[s]   = src_tag[s];
                end
            end
        end
        if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                data_q[s]  <= '0;
                shamt_q[s] <= '0;
                op_q[s]    <= '0;
                msb_q[s]   <= 1'b0;
                tag_q[s]   <= '0;
            end
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            msb_q   <= msb_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = v_q[LAT-1];
    assign out_data  = data_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results and a width/stage-grouping sweep.
module tb_shifter_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] in_data = '0, out_data;
    logic [4:0]  in_shamt = '0, in_tag = '0, out_tag;
    logic [2:0]  in_op = '0;

    logic        sw_valid = 1'b0;
    logic [2:0]  sw_op8 = '0, sw_op64 = '0;
    logic [7:0]  sw_d8 = '0, rd8;
    logic [2:0]  sw_sh8 = '0;
    logic [63:0] sw_d64 = '0, rd64;
    logic [5:0]  sw_sh64 = '0;
    logic [4:0]  rt8, rt64;
    logic        rdy8, rdy64, v8, v64;

    int total = 0, bad = 0, n_in = 0, n_out = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    shifter_pipe #(.BITS(32), .REG_EVERY(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

    shifter_pipe #(.BITS(8), .REG_EVERY(1), .TAG_W(5)) u8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(sw_valid), .in_ready(rdy8), .in_data(sw_d8),
        .in_shamt(sw_sh8), .in_op(sw_op8), .in_tag(5'd3),
        .out_valid(v8), .out_ready(1'b1), .out_data(rd8), .out_tag(rt8));

    shifter_pipe #(.BITS(64), .REG_EVERY(6), .TAG_W(5)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(sw_valid), .in_ready(rdy64), .in_data(sw_d64),
        .in_shamt(sw_sh64), .in_op(sw_op64), .in_tag(5'd9),
        .out_valid(v64), .out_ready(1'b1), .out_data(rd64), .out_tag(rt64));

    function automatic logic [31:0] ref_f(input logic [31:0] d, input int sh, input logic [2:0] op);
        case (op)
            3'b000:  return d << sh;
            3'b001:  return d >> sh;
            3'b011:  return 32'($signed(d) >>> sh);
            3'b100:  return (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
            3'b101:  return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
            default: return d;
        endcase
    endfunction

    // Every cycle: whatever is presented must be the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stale_out: got tag=%0d data=%h, required no valid output", out_tag, out_data);
                end else if ({out_tag, out_data} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL model_out: got tag=%0d data=%h, required tag=%0d data=%h",
                             out_tag, out_data, exp_q[0][36:32], exp_q[0][31:0]);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({in_tag, ref_f(in_data, int'(in_shamt), in_op)});
                    n_in++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_check(input string nm, input logic [31:0] d, input logic [4:0] sh,
                              input logic [2:0] op, input logic [4:0] tg, input logic [31:0] exp);
        int n;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op; in_tag = tg; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd3);
        chk({nm, "_data"}, 64'(out_data), 64'(exp));
        chk({nm, "_tag"}, 64'(out_tag), 64'(tg));
    endtask

    task automatic sweep(input logic [2:0] op8, input logic [7:0] d8, input logic [2:0] sh8, input logic [7:0] e8,
                         input logic [2:0] op64, input logic [63:0] d64, input logic [5:0] sh64, input logic [63:0] e64);
        sw_valid = 1'b1; sw_op8 = op8; sw_d8 = d8; sw_sh8 = sh8;
        sw_op64 = op64; sw_d64 = d64; sw_sh64 = sh64;
        tick();
        sw_valid = 1'b0;
        chk("w64_valid", 64'(v64), 64'd1);
        chk("w64_data", rd64, e64);
        tick();
        tick();
        chk("w8_valid", 64'(v8), 64'd1);
        chk("w8_data", 64'(rd8), 64'(e8));
    endtask

    initial begin
        logic [2:0]  ops [8];
        logic [31:0] held;
        int          in0, out0;
        bit          rdy_ok;
        ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110, 3'b111};

        #3;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_tag", 64'(out_tag), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        send_check("sra", 32'h8000_0000, 5'd4, 3'b011, 5'd1, 32'hF800_0000);
        send_check("srl", 32'h8000_0000, 5'd4, 3'b001, 5'd2, 32'h0800_0000);
        send_check("ror", 32'h1234_5678, 5'd8, 3'b101, 5'd3, 32'h7812_3456);
        send_check("rol", 32'h8000_0001, 5'd1, 3'b100, 5'd4, 32'h0000_0003);
        send_check("sll", 32'h0000_0001, 5'd31, 3'b000, 5'd5, 32'h8000_0000);
        send_check("sra_sh0", 32'h8000_0000, 5'd0, 3'b011, 5'd6, 32'h8000_0000);
        send_check("pass110", 32'hDEAD_BEEF, 5'd7, 3'b110, 5'd7, 32'hDEAD_BEEF);
        tick();

        // back-to-back stream
        in0 = n_in; out0 = n_out; rdy_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
            in_op = ops[i % 8]; in_tag = 5'(i);
            #1;
            if (!in_ready) rdy_ok = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_ready", 64'(rdy_ok), 64'd1);
        chk("stream_accepts", 64'(n_in - in0), 64'd32);
        chk("stream_results", 64'(n_out - out0), 64'd32);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // back-pressure
        in0 = n_in; out0 = n_out; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 32'hF000_0000 >> i; in_shamt = 5'(i);
            in_op = 3'b011; in_tag = 5'(i + 8);
            tick();
        end
        #1;
        chk("bp_accepts", 64'(n_in - in0), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_tag", 64'(out_tag), 64'd8);
        held = out_data;
        tick();
        chk("bp_hold_data", 64'(out_data), 64'(held));
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("bp_drain", 64'(n_out - out0), 64'd3);
        chk("bp_empty", 64'(exp_q.size()), 64'd0);

        // flush with a full pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i + 1); in_shamt = 5'd1; in_op = 3'b000; in_tag = 5'(i + 16);
            tick();
        end
        out_ready = 1'b1; flush = 1'b1; in_tag = 5'd20;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out0 = n_out;
        send_check("post_flush", 32'h0000_00F0, 5'd4, 3'b101, 5'd21, 32'h0000_000F);
        repeat (4) tick();
        chk("post_flush_count", 64'(n_out - out0), 64'd1);

        // async reset between edges
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hA5A5_0000 + 32'(i); in_shamt = 5'd3; in_op = 3'b100; in_tag = 5'(i + 24);
            tick();
        end
        chk("prereset_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_data", 64'(out_data), 64'd0);
        chk("areset_tag", 64'(out_tag), 64'd0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        out0 = n_out;
        repeat (5) tick();
        chk("postreset_none", 64'(n_out - out0), 64'd0);

        // width / stage-grouping sweep
        sweep(3'b110, 8'hA5, 3'd3, 8'hA5, 3'b110, 64'h0123_4567_89AB_CDEF, 6'd17, 64'h0123_4567_89AB_CDEF);
        sweep(3'b101, 8'h81, 3'd1, 8'hC0, 3'b011, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
        sweep(3'b000, 8'h03, 3'd7, 8'h80, 3'b100, 64'h8000_0000_0000_0001, 6'd4, 64'h0000_0000_0000_0018);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
